// File: rtl/alu_md_pkg.sv
`default_nettype none
// ============================================================================
// alu_md_pkg : ALU operation codes, M-extension function map, FSM states
// Rev 1.0    : initial release
// ============================================================================
package alu_md_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQ     = 5'd10,
    OP_NE     = 5'd11,
    OP_LT     = 5'd12,
    OP_GE     = 5'd13,
    OP_LTU    = 5'd14,
    OP_GEU    = 5'd15,
    OP_PASS_B = 5'd16,
    OP_MD     = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_fn_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_UPPER  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_md_controller_if.sv
`default_nettype none
// ============================================================================
// alu_md_controller_if : EX-stage decode / mul-div bus between pipeline and controller
// Rev 1.0              : initial release
// ============================================================================
interface alu_md_controller_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  logic            valid_in;
  logic [1:0]      ALUOp;
  logic            IsRType;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            flush;
  logic [OP_W-1:0] Operation;
  logic            stall;
  logic            md_done;
  logic            md_sel;
  logic [XLEN-1:0] md_result;

  modport master (
    output valid_in, ALUOp, IsRType, Funct7, Funct3, SrcA, SrcB, flush,
    input  Operation, stall, md_done, md_sel, md_result
  );

  modport slave (
    input  valid_in, ALUOp, IsRType, Funct7, Funct3, SrcA, SrcB, flush,
    output Operation, stall, md_done, md_sel, md_result
  );
endinterface
`default_nettype wire

// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
// md_iter_unit : radix-2 iterative multiplier (shift-add) / restoring divider
// Rev 1.0      : initial release
// ============================================================================
module md_iter_unit
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            abort_i,
  input  md_fn_e          fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN + 1);

  md_fn_e           fn_q;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opb_q;
  logic             neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] count_q;

  logic             a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]  mag_a, mag_b;

  always_comb begin
    a_signed = fn_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = fn_i inside {MD_MULH, MD_DIV, MD_REM};
    neg_a    = a_signed & a_i[XLEN-1];
    neg_b    = b_signed & b_i[XLEN-1];
    mag_a    = neg_a ? -a_i : a_i;
    mag_b    = neg_b ? -b_i : b_i;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // lo_q holds the multiplier (mul) or the dividend being shifted out (div);
  // acc_q is the product high half or the partial remainder.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    if (fn_q[2]) begin
      if (shifted >= {1'b0, opb_q}) begin
        acc_d = shifted[XLEN-1:0] - opb_q;
        lo_d  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = shifted[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {acc_d, lo_d};
    prod_fix = neg_quo_q ? -prod : prod;
    quo_fix  = neg_quo_q ? -lo_d : lo_d;
    rem_fix  = neg_rem_q ? -acc_d : acc_d;
    result_o = prod_fix[XLEN-1:0];
    case (fn_q)
      MD_MUL:                        result_o = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result_o = quo_fix;
      default:                       result_o = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn_q      <= MD_MUL;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
    end else if (start_i) begin
      fn_q      <= fn_i;
      acc_q     <= '0;
      lo_q      <= mag_a;
      opb_q     <= mag_b;
      neg_quo_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
      count_q   <= CNT_W'(XLEN);
    end else if (abort_i) begin
      count_q   <= '0;
    end else if (count_q != '0) begin
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      count_q   <= count_q - CNT_W'(1);
    end
  end

  assign last_o = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alu_md_controller.sv
`default_nettype none
// ============================================================================
// alu_md_controller : ALU op decoder plus mul/div sequencer for the EX stage
// Rev 1.0           : initial release
// ============================================================================
module alu_md_controller
  import alu_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input logic               clk,
  input logic               reset,
  alu_md_controller_if.slave bus
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  alu_op_e op;

  always_comb begin
    op = OP_ADD;
    case (bus.ALUOp)
      ALUOP_MEM:    op = OP_ADD;
      ALUOP_BRANCH: begin
        case (bus.Funct3)
          3'b000:  op = OP_EQ;
          3'b001:  op = OP_NE;
          3'b100:  op = OP_LT;
          3'b101:  op = OP_GE;
          3'b110:  op = OP_LTU;
          3'b111:  op = OP_GEU;
          default: op = OP_ADD;
        endcase
      end
      ALUOP_UPPER:  op = OP_PASS_B;
      ALUOP_ARITH: begin
        if (bus.IsRType && bus.Funct7 == FUNCT7_MULDIV) begin
          op = OP_MD;
        end else begin
          case (bus.Funct3)
            3'b000:  op = (bus.IsRType && bus.Funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = bus.Funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default:      op = OP_ADD;
    endcase
  end

  assign bus.Operation = OP_W'(op);

  state_e          state_q;
  logic            md_done_q;
  logic [XLEN-1:0] md_result_q;

  md_fn_e          fn;
  logic            accept, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            unit_last;
  logic [XLEN-1:0] unit_res;

  // Divide-by-zero and MIN/-1 resolve without iterating; Funct3[1] picks remainder.
  always_comb begin
    fn       = md_fn_e'(bus.Funct3);
    accept   = (state_q == ST_IDLE) && bus.valid_in && (op == OP_MD) && !bus.flush;
    div_zero = bus.Funct3[2] && (bus.SrcB == '0);
    div_ovf  = (fn == MD_DIV || fn == MD_REM) && (bus.SrcA == XMIN) && (bus.SrcB == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) begin
      fast_res = bus.Funct3[1] ? bus.SrcA : '1;
    end else begin
      fast_res = bus.Funct3[1] ? '0 : XMIN;
    end
  end

  md_iter_unit #(
    .XLEN (XLEN)
  ) u_md_iter_unit (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept && !fast),
    .abort_i  ((state_q == ST_BUSY) && bus.flush),
    .fn_i     (fn),
    .a_i      (bus.SrcA),
    .b_i      (bus.SrcB),
    .last_o   (unit_last),
    .result_o (unit_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (fast) begin
              state_q     <= ST_DONE;
              md_done_q   <= 1'b1;
              md_result_q <= fast_res;
            end else begin
              state_q     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (bus.flush) begin
            state_q     <= ST_IDLE;
          end else if (unit_last) begin
            state_q     <= ST_DONE;
            md_done_q   <= 1'b1;
            md_result_q <= unit_res;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the accepting cycle already freezes the front end.
  assign bus.stall     = !reset && (accept || state_q == ST_BUSY);
  assign bus.md_done   = md_done_q && !bus.flush;
  assign bus.md_sel    = md_done_q && !bus.flush;
  assign bus.md_result = md_result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_controller.sv
`default_nettype none
// ============================================================================
// tb_alu_md_controller : directed self-checking bench for alu_md_controller
// Rev 1.0              : initial release
// ============================================================================
module tb_alu_md_controller;
  import alu_md_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_md_controller_if #(.XLEN(XLEN), .OP_W(5)) bus ();

  alu_md_controller #(.XLEN(XLEN), .OP_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } md_vec_t;

  typedef struct {
    logic [1:0] aluop;
    logic       isr;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       valid;
    logic [4:0] exp;
  } dec_vec_t;

  task automatic idle_inputs();
    bus.valid_in = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.IsRType  = 1'b0;
    bus.Funct7   = 7'd0;
    bus.Funct3   = 3'd0;
    bus.SrcA     = '0;
    bus.SrcB     = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = 1'b1;
    bus.ALUOp    = 2'b10;
    bus.IsRType  = 1'b1;
    bus.Funct7   = 7'b0000001;
    bus.Funct3   = f3;
    bus.SrcA     = a;
    bus.SrcB     = b;
    bus.flush    = 1'b0;
  endtask

  // Starts at the negedge on which the op was driven; returns mid-DONE cycle.
  task automatic wait_md(output int stalls, output logic [31:0] res,
                         output logic sel, output bit seen);
    stalls = 0;
    res    = '0;
    sel    = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (bus.md_done) begin
        seen = 1'b1;
        res  = bus.md_result;
        sel  = bus.md_sel;
        break;
      end
      if (bus.stall) stalls++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2;
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    tests++;
    if (bus.md_done !== 1'b0 || bus.md_sel !== 1'b0) begin
      fails++; $display("FAIL reset_done got done=%b sel=%b want 0/0", bus.md_done, bus.md_sel);
    end
    tests++;
    if (bus.md_result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", bus.md_result); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_decode();
    dec_vec_t v[12];
    v[0]  = '{2'b10, 1'b1, 7'b0100000, 3'b000, 1'b1, 5'd1};
    v[1]  = '{2'b10, 1'b0, 7'b0100000, 3'b000, 1'b1, 5'd0};
    v[2]  = '{2'b01, 1'b0, 7'b0000000, 3'b110, 1'b1, 5'd14};
    v[3]  = '{2'b01, 1'b0, 7'b0000000, 3'b010, 1'b1, 5'd0};
    v[4]  = '{2'b11, 1'b0, 7'b0000000, 3'b000, 1'b1, 5'd16};
    v[5]  = '{2'b00, 1'b0, 7'b0000000, 3'b010, 1'b1, 5'd0};
    v[6]  = '{2'b10, 1'b1, 7'b0100000, 3'b101, 1'b1, 5'd7};
    v[7]  = '{2'b10, 1'b1, 7'b0000000, 3'b101, 1'b1, 5'd6};
    v[8]  = '{2'b10, 1'b1, 7'b0000000, 3'b111, 1'b1, 5'd2};
    v[9]  = '{2'b10, 1'b1, 7'b0000001, 3'b000, 1'b0, 5'd17};
    v[10] = '{2'b01, 1'b0, 7'b0000000, 3'b101, 1'b1, 5'd13};
    v[11] = '{2'b10, 1'b0, 7'b0000000, 3'b011, 1'b1, 5'd9};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.valid_in = v[i].valid;
      bus.ALUOp    = v[i].aluop;
      bus.IsRType  = v[i].isr;
      bus.Funct7   = v[i].f7;
      bus.Funct3   = v[i].f3;
      #2;
      tests++;
      if (bus.Operation !== v[i].exp || bus.stall !== 1'b0) begin
        fails++;
        $display("FAIL decode[%0d] got op=%0d stall=%b want op=%0d stall=0",
                 i, bus.Operation, bus.stall, v[i].exp);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_muldiv();
    md_vec_t v[8];
    int          stalls;
    logic [31:0] res;
    logic        sel;
    bit          seen;
    v[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    v[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    v[2] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    v[3] = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000};
    v[4] = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    v[5] = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    v[6] = '{3'b101, 32'd100,      32'd7,        32'd14};
    v[7] = '{3'b111, 32'd100,      32'd7,        32'd2};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_md(v[i].f3, v[i].a, v[i].b);
      wait_md(stalls, res, sel, seen);
      tests++;
      if (!seen) begin
        fails++; $display("FAIL md[%0d]_timeout no md_done within budget", i);
      end else begin
        if (res !== v[i].exp) begin fails++; $display("FAIL md[%0d]_result got %h want %h", i, res, v[i].exp); end
        tests++;
        if (stalls != 33) begin fails++; $display("FAIL md[%0d]_stalls got %0d want 33", i, stalls); end
        tests++;
        if (sel !== 1'b1 || bus.stall !== 1'b0) begin
          fails++; $display("FAIL md[%0d]_done_cycle got sel=%b stall=%b want 1/0", i, sel, bus.stall);
        end
      end
      idle_inputs();
    end
  endtask

  task automatic test_fast_path();
    md_vec_t v[5];
    int          stalls;
    logic [31:0] res;
    logic        sel;
    bit          seen;
    v[0] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF};
    v[1] = '{3'b110, 32'd5,        32'd0,        32'd5};
    v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    v[4] = '{3'b101, 32'd9,        32'd0,        32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_md(v[i].f3, v[i].a, v[i].b);
      wait_md(stalls, res, sel, seen);
      tests++;
      if (!seen) begin
        fails++; $display("FAIL fast[%0d]_timeout no md_done within budget", i);
      end else begin
        if (res !== v[i].exp) begin fails++; $display("FAIL fast[%0d]_result got %h want %h", i, res, v[i].exp); end
        tests++;
        if (stalls != 1) begin fails++; $display("FAIL fast[%0d]_stalls got %0d want 1", i, stalls); end
      end
      idle_inputs();
    end
  endtask

  task automatic test_flush();
    int          stalls;
    logic [31:0] res;
    logic        sel;
    bit          seen;
    bit          late_done;
    @(negedge clk);
    drive_md(3'b111, 32'd100, 32'd7);
    wait_md(stalls, res, sel, seen);
    tests++;
    if (!seen || res !== 32'd2) begin fails++; $display("FAIL flush_prior got seen=%b res=%h want 1/2", seen, res); end
    idle_inputs();
    @(negedge clk);
    drive_md(3'b000, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    #2;
    tests++;
    if (bus.stall !== 1'b0 || bus.md_done !== 1'b0) begin
      fails++; $display("FAIL flush_busy got stall=%b done=%b want 0/0", bus.stall, bus.md_done);
    end
    tests++;
    if (bus.md_result !== 32'd2) begin fails++; $display("FAIL flush_hold got %h want 00000002", bus.md_result); end
    late_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (bus.md_done) late_done = 1'b1;
    end
    tests++;
    if (late_done) begin fails++; $display("FAIL flush_no_done got md_done=1 want 0"); end
    @(negedge clk);
    drive_md(3'b000, 32'd3, 32'd5);
    bus.flush = 1'b1;
    #2;
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_idle_stall got %b want 0", bus.stall); end
    @(negedge clk);
    idle_inputs();
    #2;
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_idle_accept got stall=%b want 0", bus.stall); end
  endtask

  task automatic test_async_reset();
    int          stalls;
    logic [31:0] res;
    logic        sel;
    bit          seen;
    @(negedge clk);
    drive_md(3'b000, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.stall !== 1'b0 || bus.md_done !== 1'b0 || bus.md_sel !== 1'b0) begin
      fails++; $display("FAIL areset_ctrl got stall=%b done=%b sel=%b want 0/0/0", bus.stall, bus.md_done, bus.md_sel);
    end
    tests++;
    if (bus.md_result !== 32'h0) begin fails++; $display("FAIL areset_result got %h want 0", bus.md_result); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_md(3'b000, 32'd3, 32'd4);
    wait_md(stalls, res, sel, seen);
    tests++;
    if (!seen || res !== 32'd12 || stalls != 33) begin
      fails++; $display("FAIL areset_mul got seen=%b res=%h stalls=%0d want 1/0000000c/33", seen, res, stalls);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int          stalls;
    logic [31:0] res;
    logic        sel;
    bit          seen;
    @(negedge clk);
    drive_md(3'b000, 32'h1234, 32'h10);
    wait_md(stalls, res, sel, seen);
    tests++;
    if (!seen || res !== 32'h12340 || stalls != 33) begin
      fails++; $display("FAIL b2b_mul got seen=%b res=%h stalls=%0d want 1/00012340/33", seen, res, stalls);
    end
    drive_md(3'b100, 32'hFFFFFF00, 32'h10);
    #1;
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL b2b_done_gap got stall=%b want 0", bus.stall); end
    @(negedge clk);
    wait_md(stalls, res, sel, seen);
    tests++;
    if (!seen || res !== 32'hFFFFFFF0 || stalls != 33) begin
      fails++; $display("FAIL b2b_div got seen=%b res=%h stalls=%0d want 1/fffffff0/33", seen, res, stalls);
    end
    idle_inputs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_muldiv();
    test_fast_path();
    test_flush();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
